sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller_if.sv | 25 ++
 rtl/sram_controller.sv | 112 +++++++++++
 tb/tb_sram_controller.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_controller_if.sv
// Pipeline-side request/response signals and the external 16-bit SRAM pins
// seen by sram_controller.
interface sram_controller_if;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;

    modport slave (
        input  rd_en, wr_en, address, write_data, sram_dq_in,
        output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    modport master (
        output rd_en, wr_en, address, write_data, sram_dq_in,
        input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/sram_controller.sv
// Splits each 32-bit load/store into two timed 16-bit SRAM half-accesses,
// freezing the pipeline through ready until the transaction completes.
module sram_controller #(
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned MEM_BASE      = 1024
) (
    input  logic             clk,
    input  logic             rst,
    sram_controller_if.slave bus
);
    localparam int unsigned      CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [16:0]      word_q;
    logic [31:0]      wdata_q;
    logic             wr_q;

    logic [31:0]      offset_c;
    logic [CNT_W-1:0] cnt_inc_c;
    logic             last_c;
    logic             we_active_next_c;
    logic             unused_offset;

    // Offset wraps modulo 2^32; byte-lane bits and bits above the SRAM range are dropped.
    assign offset_c         = bus.address - MEM_BASE;
    assign unused_offset    = ^{offset_c[31:19], offset_c[1:0]};
    assign cnt_inc_c        = cnt + CNT_W'(1);
    assign last_c           = (cnt == LAST);
    assign we_active_next_c = wr_q && (cnt_inc_c != LAST);

    assign bus.ready = ((state == IDLE) && !bus.rd_en && !bus.wr_en) || (state == DONE);

    // Pin outputs are registered one cycle ahead so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= IDLE;
            cnt             <= '0;
            word_q          <= '0;
            wdata_q         <= '0;
            wr_q            <= 1'b0;
            bus.read_data   <= '0;
            bus.sram_addr   <= '0;
            bus.sram_dq_out <= '0;
            bus.sram_dq_oe  <= 1'b0;
            bus.sram_we_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.rd_en || bus.wr_en) begin
                        state           <= LOW;
                        cnt             <= '0;
                        word_q          <= offset_c[18:2];
                        wdata_q         <= bus.write_data;
                        wr_q            <= bus.wr_en;
                        bus.sram_addr   <= {offset_c[18:2], 1'b0};
                        bus.sram_dq_oe  <= bus.wr_en;
                        bus.sram_dq_out <= bus.wr_en ? bus.write_data[15:0] : 16'h0000;
                        bus.sram_we_n   <= !bus.wr_en;
                    end
                end

                LOW: begin
                    if (last_c) begin
                        if (!wr_q) begin
                            bus.read_data[15:0] <= bus.sram_dq_in;
                        end
                        state           <= HIGH;
                        cnt             <= '0;
                        bus.sram_addr   <= {word_q, 1'b1};
                        bus.sram_dq_oe  <= wr_q;
                        bus.sram_dq_out <= wr_q ? wdata_q[31:16] : 16'h0000;
                        bus.sram_we_n   <= !wr_q;
                    end else begin
                        cnt             <= cnt_inc_c;
                        bus.sram_dq_out <= wr_q ? wdata_q[15:0] : 16'h0000;
                        bus.sram_we_n   <= !we_active_next_c;
                    end
                end

                HIGH: begin
                    if (last_c) begin
                        if (!wr_q) begin
                            bus.read_data[31:16] <= bus.sram_dq_in;
                        end
                        state           <= DONE;
                        cnt             <= '0;
                        bus.sram_addr   <= '0;
                        bus.sram_dq_oe  <= 1'b0;
                        bus.sram_dq_out <= '0;
                        bus.sram_we_n   <= 1'b1;
                    end else begin
                        cnt             <= cnt_inc_c;
                        bus.sram_dq_out <= wr_q ? wdata_q[31:16] : 16'h0000;
                        bus.sram_we_n   <= !we_active_next_c;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: directed vector table, multi-cycle
// corner sequences and randomized transactions against a word-level memory model.
module tb_sram_controller;
    localparam int unsigned MEM_BASE = 1024;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        use4;
    logic        mem_init;

    int total;
    int bad;

    sram_controller_if b2();
    sram_controller_if b4();

    sram_controller #(.ACCESS_CYCLES(2), .MEM_BASE(MEM_BASE)) dut2 (.clk(clk), .rst(rst), .bus(b2));
    sram_controller #(.ACCESS_CYCLES(4), .MEM_BASE(MEM_BASE)) dut4 (.clk(clk), .rst(rst), .bus(b4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Request inputs steered to whichever controller is under test.
    assign b2.rd_en      = rd_en & ~use4;
    assign b2.wr_en      = wr_en & ~use4;
    assign b2.address    = address;
    assign b2.write_data = write_data;
    assign b4.rd_en      = rd_en & use4;
    assign b4.wr_en      = wr_en & use4;
    assign b4.address    = address;
    assign b4.write_data = write_data;

    // SRAM pin models
    logic [15:0] mem2 [1024];
    logic [15:0] mem4 [1024];
    assign b2.sram_dq_in = mem2[b2.sram_addr[9:0]];
    assign b4.sram_dq_in = mem4[b4.sram_addr[9:0]];

    function automatic logic [15:0] seed(input int i);
        if (i == 4) return 16'h5678;
        if (i == 5) return 16'h1234;
        return 16'(i * 37 + 256);
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) begin
                mem2[i] <= seed(i);
                mem4[i] <= seed(i);
            end
        end else begin
            if (b2.sram_dq_oe && !b2.sram_we_n) mem2[b2.sram_addr[9:0]] <= b2.sram_dq_out;
            if (b4.sram_dq_oe && !b4.sram_we_n) mem4[b4.sram_addr[9:0]] <= b4.sram_dq_out;
        end
    end

    // Observed outputs of the controller under test
    logic        o_ready;
    logic [31:0] o_rdata;
    logic [17:0] o_addr;
    logic [15:0] o_dq;
    logic        o_oe;
    logic        o_we_n;
    assign o_ready = use4 ? b4.ready       : b2.ready;
    assign o_rdata = use4 ? b4.read_data   : b2.read_data;
    assign o_addr  = use4 ? b4.sram_addr   : b2.sram_addr;
    assign o_dq    = use4 ? b4.sram_dq_out : b2.sram_dq_out;
    assign o_oe    = use4 ? b4.sram_dq_oe  : b2.sram_dq_oe;
    assign o_we_n  = use4 ? b4.sram_we_n   : b2.sram_we_n;

    // Reference model: 32-bit words stored as half-word pairs, plus last load value
    logic [15:0] refmem [1024];
    logic [31:0] ref_rd;

    function automatic int half_idx(input logic [31:0] addr, input int h);
        logic [31:0] off;
        off = addr - 32'(MEM_BASE);
        return ((int'(off >> 2) % 131072) * 2 + h) % 1024;
    endfunction

    task automatic model_txn(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd, output logic [31:0] exp_rd);
        if (wr) begin
            refmem[half_idx(addr, 0)] = wd[15:0];
            refmem[half_idx(addr, 1)] = wd[31:16];
        end else if (rd) begin
            ref_rd = {refmem[half_idx(addr, 1)], refmem[half_idx(addr, 0)]};
        end
        exp_rd = ref_rd;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered just after a rising edge with the controller idle; returns likewise.
    task automatic do_txn(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd);
        int          a;
        int          h;
        logic        last;
        logic [16:0] w;
        a = use4 ? 4 : 2;
        w = 17'((addr - 32'(MEM_BASE)) >> 2);
        rd_en = rd; wr_en = wr; address = addr; write_data = wd;
        @(negedge clk);
        chk("ready_req_cycle", 64'(o_ready), 64'(0));
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0; address = $urandom; write_data = $urandom;
        for (int k = 1; k <= 2 * a + 1; k++) begin
            @(negedge clk);
            if (k <= 2 * a) begin
                h    = (k > a) ? 1 : 0;
                last = (k == a) || (k == 2 * a);
                chk("ready_busy", 64'(o_ready), 64'(0));
                chk("sram_addr", 64'(o_addr), 64'({w, 1'(h)}));
                chk("dq_oe", 64'(o_oe), 64'(wr));
                chk("we_n", 64'(o_we_n), wr ? 64'(last) : 64'(1));
                chk("dq_out", 64'(o_dq), wr ? 64'(h ? wd[31:16] : wd[15:0]) : 64'(0));
            end else begin
                chk("ready_done", 64'(o_ready), 64'(1));
                chk("read_data", 64'(o_rdata), 64'(exp_rd));
                chk("done_addr", 64'(o_addr), 64'(0));
                chk("done_we_n", 64'(o_we_n), 64'(1));
                chk("done_oe", 64'(o_oe), 64'(0));
            end
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] e;
        logic [31:0] e2;
        logic [31:0] a;
        logic [31:0] d;
        logic        rd;
        logic        wr;
        int          op;
        logic [16:0] w1;
        logic [16:0] w2;
        total = 0; bad = 0;
        rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
        use4 = 1'b0; mem_init = 1'b1;
        for (int i = 0; i < 1024; i++) refmem[i] = seed(i);
        ref_rd = '0;

        vecs[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h00000000};
        vecs[1] = '{1'b1, 1'b0, 32'd1032, 32'h0,        32'h12345678};
        vecs[2] = '{1'b1, 1'b1, 32'd1028, 32'h0000A5A5, 32'h12345678};
        vecs[3] = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'h0000A5A5};
        vecs[4] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'hDEADBEEF};
        vecs[5] = '{1'b1, 1'b0, 32'd1027, 32'h0,        32'hDEADBEEF};
        vecs[6] = '{1'b1, 1'b0, 32'd3070, 32'h0,        32'h94DB94B6};
        vecs[7] = '{1'b0, 1'b1, 32'd1020, 32'hCAFEF00D, 32'h94DB94B6};
        vecs[8] = '{1'b1, 1'b0, 32'd1020, 32'h0,        32'hCAFEF00D};

        repeat (3) @(posedge clk);
        #1; rst = 1'b1; mem_init = 1'b0;
        @(negedge clk);
        chk("rst_ready", 64'(o_ready), 64'(1));
        chk("rst_read_data", 64'(o_rdata), 64'(0));
        chk("rst_we_n", 64'(o_we_n), 64'(1));
        chk("rst_oe", 64'(o_oe), 64'(0));
        chk("rst_addr", 64'(o_addr), 64'(0));
        chk("rst_dq_out", 64'(o_dq), 64'(0));
        chk("rst_read_data4", 64'(b4.read_data), 64'(0));
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            model_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, e);
            do_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd);
        end

        // Back-to-back reads with requests held high; address changes mid-flight.
        w1 = 17'((32'd1040 - 32'(MEM_BASE)) >> 2);
        w2 = 17'((32'd1048 - 32'(MEM_BASE)) >> 2);
        model_txn(1'b1, 1'b0, 32'd1040, 32'h0, e);
        model_txn(1'b1, 1'b0, 32'd1048, 32'h0, e2);
        rd_en = 1'b1; address = 32'd1040;
        @(negedge clk);
        chk("b2b_req_ready", 64'(o_ready), 64'(0));
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk); #1;
            if (k == 1) address = 32'd1048;
            if (k == 7) rd_en = 1'b0;
            @(negedge clk);
            if (k <= 4) chk("b2b_addr1", 64'(o_addr), 64'({w1, 1'(k > 2)}));
            if (k == 5) begin
                chk("b2b_ready1", 64'(o_ready), 64'(1));
                chk("b2b_rdata1", 64'(o_rdata), 64'(e));
            end
            if (k == 6) begin
                chk("b2b_gap_ready", 64'(o_ready), 64'(0));
                chk("b2b_gap_addr", 64'(o_addr), 64'(0));
            end
            if (k >= 7 && k <= 10) chk("b2b_addr2", 64'(o_addr), 64'({w2, 1'(k > 8)}));
            if (k == 11) begin
                chk("b2b_ready2", 64'(o_ready), 64'(1));
                chk("b2b_rdata2", 64'(o_rdata), 64'(e2));
            end
            if (k >= 12) begin
                chk("b2b_no_dup_ready", 64'(o_ready), 64'(1));
                chk("b2b_no_dup_addr", 64'(o_addr), 64'(0));
            end
        end
        @(posedge clk); #1;

        // Reset during the upper half of a write.
        w1 = 17'((32'd1100 - 32'(MEM_BASE)) >> 2);
        wr_en = 1'b1; address = 32'd1100; write_data = 32'h11112222;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            if (k == 1) wr_en = 1'b0;
            if (k == 3) rst = 1'b0;
            if (k == 4) rst = 1'b1;
            @(negedge clk);
            if (k == 3) chk("rst_mid_high_addr", 64'(o_addr), 64'({w1, 1'b1}));
            if (k == 4) begin
                chk("rst_mid_rdata", 64'(o_rdata), 64'(0));
                chk("rst_mid_addr", 64'(o_addr), 64'(0));
            end
            if (k >= 4) begin
                chk("rst_mid_we_n", 64'(o_we_n), 64'(1));
                chk("rst_mid_oe", 64'(o_oe), 64'(0));
                chk("rst_mid_ready", 64'(o_ready), 64'(1));
            end
        end
        @(posedge clk); #1;
        ref_rd = '0;
        refmem[half_idx(32'd1100, 0)] = 16'h2222;
        model_txn(1'b0, 1'b1, 32'd1100, 32'h33334444, e);
        do_txn(1'b0, 1'b1, 32'd1100, 32'h33334444, e);
        model_txn(1'b1, 1'b0, 32'd1100, 32'h0, e);
        do_txn(1'b1, 1'b0, 32'd1100, 32'h0, e);

        // Four-cycle half-accesses: write then read back through the SRAM model.
        use4 = 1'b1;
        do_txn(1'b0, 1'b1, 32'd1040, 32'hBADC0FFE, 32'h0);
        do_txn(1'b1, 1'b0, 32'd1040, 32'h0, 32'hBADC0FFE);
        use4 = 1'b0;

        // Randomized transactions with idle gaps.
        for (int n = 0; n < 40; n++) begin
            op = int'($urandom_range(0, 2));
            wr = (op != 0);
            rd = (op != 1);
            a  = 32'(MEM_BASE) + $urandom_range(0, 2047);
            d  = $urandom;
            model_txn(rd, wr, a, d, e);
            do_txn(rd, wr, a, d, e);
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
                @(negedge clk);
                chk("idle_ready", 64'(o_ready), 64'(1));
                @(posedge clk); #1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
